// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared definitions for the LCD bus controller.
// FSM state encoding, LCD word field positions, command constants and the
// power-on init command ROM used when LCD_CTRL_INIT_EN is defined.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_BOOT  = 3'd5
    } state_e;

    // Field positions inside the 32-bit LCD word
    localparam int BIT_ON   = 31;
    localparam int BIT_RS   = 9;
    localparam int BIT_RW   = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Commands that need the long execution wait
    localparam logic [7:0] CMD_CLR      = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    // Power-on init: ten long waits, then four commands
    localparam int INIT_BOOT_REPS = 10;
    localparam int INIT_LEN       = 4;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    return 8'h0C;   // display on, cursor off
            2'd2:    return CMD_CLR; // clear display
            default: return 8'h06;   // entry mode: increment, no shift
        endcase
    endfunction

    // Clear and home are the slow instructions; everything else is T_EXEC
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every bus phase.
// Counts toward zero and parks there; a load overrides the count.
module lcd_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement but never wrap past zero
    always_comb begin
        // NOTE: default assignment first so every path writes cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking updates so every flop samples pre-edge values.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns each CPU write of the LCD word into a timed HD44780 bus
// transaction (setup, EN pulse, hold, execution wait) with a one-deep
// pending slot, a busy flag and a sticky overflow flag.
// Define LCD_CTRL_INIT_EN to run the power-on init sequence after reset.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 82000,
    parameter int CNT_W   = 17
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_i,
    input  logic [31:0] lcd_word_i,
    output logic        lcd_on_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        overflow_o
);

`ifdef LCD_CTRL_INIT_EN
    localparam state_e RESET_STATE = ST_BOOT;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e           state_q, state_d;
    logic             timer_load, timer_zero;
    logic [CNT_W-1:0] timer_val;
    logic             launch, launch_rs;
    logic [7:0]       launch_data;
    logic             start_cpu, take_pend, direct_wr, capture, drop;
    logic             pend_valid_q, pend_valid_d, pend_rs_q;
    logic [7:0]       pend_data_q;
    logic             rs_q, on_q, ovf_q, busy_q;
    logic [7:0]       data_q;
    logic             unused_word_bits;
`ifdef LCD_CTRL_INIT_EN
    logic [3:0]       boot_rep_q;
    logic [2:0]       init_idx_q;
    logic             init_left, launch_init, boot_step;

    assign init_left = (init_idx_q < 3'(INIT_LEN));
`endif

    // RW and the reserved bits never influence the bus
    assign unused_word_bits = ^{lcd_word_i[BIT_ON-1:BIT_RS+1], lcd_word_i[BIT_RW]};

    lcd_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // Pending-slot bookkeeping: drain first, then capture, else drop
    always_comb begin
        start_cpu    = (state_q == ST_IDLE) && (pend_valid_q || wr_i);
        take_pend    = start_cpu && pend_valid_q;
        direct_wr    = start_cpu && !pend_valid_q;
        capture      = wr_i && !direct_wr && (!pend_valid_q || take_pend);
        drop         = wr_i && pend_valid_q && !take_pend;
        pend_valid_d = (pend_valid_q && !take_pend) || capture;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each timed phase ends when the timer reads zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_cpu)  state_d = ST_SETUP;
            ST_SETUP: if (timer_zero) state_d = ST_PULSE;
            ST_PULSE: if (timer_zero) state_d = ST_HOLD;
            ST_HOLD:  if (timer_zero) state_d = ST_WAIT;
`ifdef LCD_CTRL_INIT_EN
            ST_WAIT:  if (timer_zero) state_d = init_left ? ST_SETUP : ST_IDLE;
            ST_BOOT:  if (timer_zero && (boot_rep_q == 4'(INIT_BOOT_REPS))) state_d = ST_SETUP;
`else
            ST_WAIT:  if (timer_zero) state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: EN strobe, timer reloads and the command being launched
    always_comb begin
        lcd_en_o    = (state_q == ST_PULSE);
        timer_load  = 1'b0;
        timer_val   = '0;
        launch      = 1'b0;
        launch_rs   = 1'b0;
        launch_data = '0;
`ifdef LCD_CTRL_INIT_EN
        launch_init = 1'b0;
        boot_step   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_cpu) begin
                    timer_load = 1'b1;
                    timer_val  = CNT_W'(T_SETUP - 1);
                    launch     = 1'b1;
                    if (pend_valid_q) begin
                        launch_rs   = pend_rs_q;
                        launch_data = pend_data_q;
                    end else begin
                        launch_rs   = lcd_word_i[BIT_RS];
                        launch_data = lcd_word_i[DATA_MSB:DATA_LSB];
                    end
                end
            end
            ST_SETUP: begin
                timer_load = timer_zero;
                timer_val  = CNT_W'(T_PULSE - 1);
            end
            ST_PULSE: begin
                timer_load = timer_zero;
                timer_val  = CNT_W'(T_HOLD - 1);
            end
            ST_HOLD: begin
                timer_load = timer_zero;
                timer_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(T_LONG - 1) : CNT_W'(T_EXEC - 1);
            end
`ifdef LCD_CTRL_INIT_EN
            ST_WAIT: begin
                if (timer_zero && init_left) begin
                    launch_init = 1'b1;
                end
            end
            ST_BOOT: begin
                if (timer_zero) begin
                    if (boot_rep_q == 4'(INIT_BOOT_REPS)) begin
                        launch_init = 1'b1;
                    end else begin
                        // The post-reset cycle counts toward the first period
                        boot_step  = 1'b1;
                        timer_load = 1'b1;
                        timer_val  = (boot_rep_q == '0) ? CNT_W'(T_LONG - 2) : CNT_W'(T_LONG - 1);
                    end
                end
            end
`endif
            default: ;
        endcase
`ifdef LCD_CTRL_INIT_EN
        if (launch_init) begin
            timer_load  = 1'b1;
            timer_val   = CNT_W'(T_SETUP - 1);
            launch      = 1'b1;
            launch_rs   = 1'b0;
            launch_data = init_cmd(init_idx_q[1:0]);
        end
`endif
    end

    // Bus fields, power bit, slot valid, overflow and busy flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs_q         <= 1'b0;
            data_q       <= '0;
            on_q         <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            pend_valid_q <= 1'b0;
        end else begin
            if (launch) begin
                rs_q   <= launch_rs;
                data_q <= launch_data;
            end
            if (wr_i && !drop) begin
                on_q <= lcd_word_i[BIT_ON];
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            pend_valid_q <= pend_valid_d;
            busy_q       <= (state_d != ST_IDLE) || pend_valid_d;
        end
    end

    // Pending payload, written whenever a word is parked in the slot
    always_ff @(posedge clk_i) begin
        // NOTE: payload flops carry no reset; pend_valid_q alone says whether they hold a word.
        if (capture) begin
            pend_rs_q   <= lcd_word_i[BIT_RS];
            pend_data_q <= lcd_word_i[DATA_MSB:DATA_LSB];
        end
    end

`ifdef LCD_CTRL_INIT_EN
    // Boot period counter and init ROM pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            boot_rep_q <= '0;
            init_idx_q <= '0;
        end else begin
            if (boot_step) begin
                boot_rep_q <= boot_rep_q + 1'b1;
            end
            if (launch_init) begin
                init_idx_q <= init_idx_q + 1'b1;
            end
        end
    end
`endif

    assign lcd_on_o   = on_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = data_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: table of per-cycle vectors, hand-written corner sequences and
// a randomized run compared against a transaction-level timing model.
module tb_lcd_ctrl;

    localparam int TS = 2;
    localparam int TP = 3;
    localparam int TH = 2;
    localparam int TE = 10;
    localparam int TL = 40;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_i = 1'b0;
    logic [31:0] lcd_word_i = '0;
    logic        lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, busy_o, overflow_o;
    logic [7:0]  lcd_data_o;

    int total = 0;
    int bad   = 0;

    lcd_ctrl #(
        .T_SETUP (TS),
        .T_PULSE (TP),
        .T_HOLD  (TH),
        .T_EXEC  (TE),
        .T_LONG  (TL),
        .CNT_W   (17)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_i       (wr_i),
        .lcd_word_i (lcd_word_i),
        .lcd_on_o   (lcd_on_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_rw_o   (lcd_rw_o),
        .lcd_en_o   (lcd_en_o),
        .lcd_data_o (lcd_data_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- transaction-level reference model ----------------
    // A transaction started at edge s occupies edges s .. s+dur-1; EN is
    // high for TS <= (edge - s) < TS+TP. Nothing here tracks FSM states.
    bit          m_act, m_pv, m_rs, m_on, m_ovf;
    logic [7:0]  m_data;
    logic [31:0] m_pw;
    int          m_edge, m_start, m_dur;

    function automatic int exec_len(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return TL;
        return TE;
    endfunction

    task automatic model_launch(input logic [31:0] w);
        m_act   = 1'b1;
        m_start = m_edge;
        m_rs    = w[9];
        m_data  = w[7:0];
        m_dur   = TS + TP + TH + exec_len(w[9], w[7:0]);
    endtask

    task automatic model_edge(input bit r, input bit w, input logic [31:0] d);
        bit idle;
        if (r) begin
            m_act = 0; m_pv = 0; m_rs = 0; m_data = '0; m_on = 0; m_ovf = 0;
            m_edge = 0; m_start = 0; m_dur = 0;
            return;
        end
        idle = !m_act || (m_edge - m_start >= m_dur);
        m_edge++;
        if (idle && m_pv) begin
            model_launch(m_pw);
            m_pv = w;
            if (w) begin
                m_pw = d;
                m_on = d[31];
            end
        end else if (idle && w) begin
            model_launch(d);
            m_on = d[31];
        end else if (w) begin
            if (m_pv) begin
                m_ovf = 1'b1;
            end else begin
                m_pv = 1'b1;
                m_pw = d;
                m_on = d[31];
            end
        end
    endtask

    function automatic logic [13:0] model_vec();
        int r;
        bit inprog, en;
        r      = m_edge - m_start;
        inprog = m_act && (r < m_dur);
        en     = inprog && (r >= TS) && (r < TS + TP);
        return {m_on, m_rs, 1'b0, en, m_data, inprog || m_pv, m_ovf};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [13:0] dut_vec();
        return {lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o, busy_o, overflow_o};
    endfunction

    function automatic logic [13:0] exp_vec(input bit on, input bit rs, input bit en,
                                            input logic [7:0] data, input bit busy, input bit ovf);
        return {on, rs, 1'b0, en, data, busy, ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, settle.
    task automatic cyc(input bit r, input bit w, input logic [31:0] d);
        rst_i      = r;
        wr_i       = w;
        lcd_word_i = d;
        @(posedge clk_i);
        model_edge(r, w, d);
        #1;
        rst_i = 1'b0;
        wr_i  = 1'b0;
    endtask

    task automatic idle_n(input int n);
        repeat (n) cyc(1'b0, 1'b0, '0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: begin w[9] = 1'b0; w[7:0] = 8'(1 + $urandom_range(0, 2)); end
            1: begin w[9] = 1'b0; w[7:0] = 8'h80; end
            default: ;
        endcase
        return w;
    endfunction

    typedef struct {
        int          rep;
        bit          rst;
        bit          wr;
        logic [31:0] word;
        bit          on;
        bit          rs;
        bit          en;
        logic [7:0]  data;
        bit          busy;
        bit          ovf;
    } vec_t;

    vec_t        vecs[$];
    bit          r_rst, r_wr;
    logic [31:0] r_word;

    initial begin
        // rep, rst, wr, word, on, rs, en, data, busy, ovf
        vecs.push_back('{1, 1, 0, 32'h0,         0, 0, 0, 8'h00, 0, 0}); // reset
        vecs.push_back('{2, 0, 0, 32'h0,         0, 0, 0, 8'h00, 0, 0});
        vecs.push_back('{1, 0, 1, 32'h8000_0241, 1, 1, 0, 8'h41, 1, 0}); // data write
        vecs.push_back('{1, 0, 0, 32'h0,         1, 1, 0, 8'h41, 1, 0}); // setup
        vecs.push_back('{3, 0, 0, 32'h0,         1, 1, 1, 8'h41, 1, 0}); // pulse
        vecs.push_back('{2, 0, 0, 32'h0,         1, 1, 0, 8'h41, 1, 0}); // hold
        vecs.push_back('{10, 0, 0, 32'h0,        1, 1, 0, 8'h41, 1, 0}); // exec wait
        vecs.push_back('{2, 0, 0, 32'h0,         1, 1, 0, 8'h41, 0, 0}); // idle
        vecs.push_back('{1, 0, 1, 32'h0000_0001, 0, 0, 0, 8'h01, 1, 0}); // clear cmd
        vecs.push_back('{1, 0, 0, 32'h0,         0, 0, 0, 8'h01, 1, 0});
        vecs.push_back('{3, 0, 0, 32'h0,         0, 0, 1, 8'h01, 1, 0});
        vecs.push_back('{2, 0, 0, 32'h0,         0, 0, 0, 8'h01, 1, 0});
        vecs.push_back('{40, 0, 0, 32'h0,        0, 0, 0, 8'h01, 1, 0}); // long wait
        vecs.push_back('{1, 0, 0, 32'h0,         0, 0, 0, 8'h01, 0, 0});
        vecs.push_back('{1, 0, 1, 32'h0000_0180, 0, 0, 0, 8'h80, 1, 0}); // RW bit set, ignored
        vecs.push_back('{1, 0, 0, 32'h0,         0, 0, 0, 8'h80, 1, 0});
        vecs.push_back('{3, 0, 0, 32'h0,         0, 0, 1, 8'h80, 1, 0});
        vecs.push_back('{2, 0, 0, 32'h0,         0, 0, 0, 8'h80, 1, 0});
        vecs.push_back('{10, 0, 0, 32'h0,        0, 0, 0, 8'h80, 1, 0});
        vecs.push_back('{2, 0, 0, 32'h0,         0, 0, 0, 8'h80, 0, 0});

        foreach (vecs[k]) begin
            for (int j = 0; j < vecs[k].rep; j++) begin
                cyc(vecs[k].rst, vecs[k].wr && (j == 0), vecs[k].word);
                check($sformatf("vec%0d.%0d", k, j), 32'(dut_vec()),
                      32'(exp_vec(vecs[k].on, vecs[k].rs, vecs[k].en,
                                  vecs[k].data, vecs[k].busy, vecs[k].ovf)));
            end
        end

        // A executes, B waits in the slot, C is dropped
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h8000_0241);          // e0
        cyc(1'b0, 1'b1, 32'h8000_0242);          // e1
        cyc(1'b0, 1'b1, 32'h8000_0243);          // e2
        check("abc_ovf_set", 32'(overflow_o), 32'd1);
        check("abc_a_data", 32'(lcd_data_o), 32'h41);
        idle_n(14);                              // e16, last WAIT cycle of A
        check("abc_a_wait_busy", 32'(busy_o), 32'd1);
        idle_n(1);                               // e17, IDLE with slot full
        check("abc_idle_busy", 32'(busy_o), 32'd1);
        check("abc_idle_data", 32'(lcd_data_o), 32'h41);
        idle_n(1);                               // e18, B launched
        check("abc_b_data", 32'(lcd_data_o), 32'h42);
        check("abc_b_en_low", 32'(lcd_en_o), 32'd0);
        idle_n(2);                               // e20
        check("abc_b_en", 32'(lcd_en_o), 32'd1);
        idle_n(15);                              // e35, B done
        check("abc_done_busy", 32'(busy_o), 32'd0);
        check("abc_done_data", 32'(lcd_data_o), 32'h42);
        check("abc_ovf_sticky", 32'(overflow_o), 32'd1);

        // Write on the cycle the slot drains: nothing lost
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h8000_0241);          // e0
        cyc(1'b0, 1'b1, 32'h8000_0255);          // e1, parked
        idle_n(16);                              // e17, IDLE
        check("drain_idle_busy", 32'(busy_o), 32'd1);
        cyc(1'b0, 1'b1, 32'h0000_0266);          // e18, drain + capture
        check("drain_b_data", 32'(lcd_data_o), 32'h55);
        check("drain_ovf", 32'(overflow_o), 32'd0);
        check("drain_on", 32'(lcd_on_o), 32'd0);
        idle_n(17);                              // e35
        check("drain_wait_busy", 32'(busy_o), 32'd1);
        check("drain_wait_data", 32'(lcd_data_o), 32'h55);
        idle_n(1);                               // e36, D launched
        check("drain_d_data", 32'(lcd_data_o), 32'h66);
        idle_n(17);                              // e53
        check("drain_done_busy", 32'(busy_o), 32'd0);
        check("drain_ovf_end", 32'(overflow_o), 32'd0);

        // Reset during PULSE, then a cold write
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h8000_0241);
        idle_n(2);
        check("rst_pulse_en", 32'(lcd_en_o), 32'd1);
        cyc(1'b1, 1'b0, '0);
        check("rst_all_zero", 32'(dut_vec()), 32'd0);
        cyc(1'b0, 1'b1, 32'h8000_0241);
        check("cold_busy", 32'(busy_o), 32'd1);
        check("cold_en0", 32'(lcd_en_o), 32'd0);
        idle_n(1);
        check("cold_en1", 32'(lcd_en_o), 32'd0);
        idle_n(1);
        check("cold_en_rise", 32'(lcd_en_o), 32'd1);
        idle_n(3);
        check("cold_en_fall", 32'(lcd_en_o), 32'd0);

        // Randomized traffic against the timing model
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 3000; i++) begin
            r_rst  = ($urandom_range(0, 399) == 0);
            r_wr   = ($urandom_range(0, 8) == 0);
            r_word = rand_word();
            cyc(r_rst, r_wr, r_word);
            check($sformatf("rand%0d", i), 32'(dut_vec()), 32'(model_vec()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
